// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//
// Four-digit multiplexed hexadecimal driver for a common-anode 7-segment
// module. A prescaler divides clk into digit slots of PRESCALE cycles. A 2-bit
// scan index rotates the anodes. The input value is snapshotted once per
// four-slot frame, so every digit of a frame shows one coherent count.
//
// Optional feature (compile-time macro):
//   SEG7_LZB_EN  - leading-zero blanking. Digit k (k = 1..3) keeps its anode
//                  off when shadow[15:4k] == 0. Digit 0 is always shown.
//                  When the macro is undefined, all four digits are always
//                  lit.
//
// Parameters:
//   PRESCALE  clock cycles per digit slot (>= 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   value    in   [15:0] value to display, digit k = value[4k+3:4k]
//   dp_mask  in   [3:0]  decimal point request per digit (1 = lit), sampled live
//   blank    in   1 turns all anodes and the dp off (scan keeps running)
//   an       out  [3:0]  anode enables, active-low
//   seg      out  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp       out  decimal point, active-low
//   frame    out  one-cycle pulse when a new snapshot is loaded
// -----------------------------------------------------------------------------
module seg7_scan_display #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int unsigned PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PC_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pc;
   logic          tick;
   logic [1:0]    d;
   logic          run;
   logic [15:0]   shadow;
   logic [3:0]    nibble;
   logic          digit_lit;
   logic          show;

   // Hex digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      s = 7'h7F;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign tick = (pc == PC_MAX);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= '0;
      end else if (tick) begin
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

   // Scan state. The snapshot is taken on the first tick after reset and at
   // every wrap from digit 3, which is what keeps a frame coherent.
   // NOTE: shadow is a plain 16-bit register, not a memory, so it is reset
   // along with the rest of the state and seg never shows undefined data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d      <= 2'd0;
         run    <= 1'b0;
         shadow <= 16'h0000;
         frame  <= 1'b0;
      end else if (tick) begin
         if (!run || d == 2'd3) begin
            d      <= 2'd0;
            shadow <= value;
            run    <= 1'b1;
            frame  <= 1'b1;
         end else begin
            d     <= d + 2'd1;
            frame <= 1'b0;
         end
      end else begin
         frame <= 1'b0;
      end
   end

   // Nibble of the snapshot that belongs to the current digit.
   // NOTE: every combinational output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      nibble = shadow[3:0];
      case (d)
         2'd1:    nibble = shadow[7:4];
         2'd2:    nibble = shadow[11:8];
         2'd3:    nibble = shadow[15:12];
         default: nibble = shadow[3:0];
      endcase
   end

`ifdef SEG7_LZB_EN
   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      digit_lit = 1'b1;
      case (d)
         2'd1:    digit_lit = |shadow[15:4];
         2'd2:    digit_lit = |shadow[15:8];
         2'd3:    digit_lit = |shadow[15:12];
         default: digit_lit = 1'b1;
      endcase
   end
`else
   assign digit_lit = 1'b1;
`endif

   assign show = run && !blank && digit_lit;

   // Output register, loaded from the current state (not next-state). This
   // gives exactly one cycle from a state change to the pins and keeps the
   // pins glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= show ? ~(4'b0001 << d) : 4'b1111;
         seg <= run ? hex_to_seg(nibble) : 7'b1111111;
         dp  <= show ? ~dp_mask[d] : 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_display
//
// Directed bench for seg7_scan_display with PRESCALE = 4. It covers reset
// values, the first tick after reset, full scan frames, the mid-frame snapshot,
// blank and dp behaviour, leading zeros (either build) and an asynchronous
// reset during a scan. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_display;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   int n_checks = 0;
   int n_errors = 0;

   // Expected active-low patterns, packed {digit3, digit2, digit1, digit0}.
   localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] SEG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};
   localparam logic [27:0] SEG_0070 = {7'h40, 7'h40, 7'h78, 7'h40};
   localparam logic [27:0] SEG_0000 = {7'h40, 7'h40, 7'h40, 7'h40};

`ifdef SEG7_LZB_EN
   localparam logic [3:0] LIT_0070 = 4'b0011;
   localparam logic [3:0] LIT_0000 = 4'b0001;
`else
   localparam logic [3:0] LIT_0070 = 4'b1111;
   localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

   seg7_scan_display #(.PRESCALE(P)) dut (
      .clk     (clk),
      .rst     (rst),
      .value   (value),
      .dp_mask (dp_mask),
      .blank   (blank),
      .an      (an),
      .seg     (seg),
      .dp      (dp),
      .frame   (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " an"},    32'(an),    32'h0000000F);
      check({tag, " seg"},   32'(seg),   32'h0000007F);
      check({tag, " dp"},    32'(dp),    32'h00000001);
      check({tag, " frame"}, 32'(frame), 32'h00000000);
   endtask

   // Called right after reset release. The first tick is on edge P, so frame
   // is high after edge P and the pins stay dark until then.
   task automatic startup(input string tag);
      for (int i = 1; i <= P; i++) begin
         @(negedge clk);
         check($sformatf("%s frame c%0d", tag, i), 32'(frame), 32'(i == P));
         check($sformatf("%s an c%0d", tag, i),    32'(an),    32'h0000000F);
         check($sformatf("%s seg c%0d", tag, i),   32'(seg),   32'h0000007F);
      end
   endtask

   // Checks one full frame, starting from the falling edge where frame is
   // high. It ends on the falling edge where the next frame pulse is high.
   // Edges b_lo..b_hi see blank = 1. value becomes chg_val after negedge
   // chg_at (0 = no change).
   task automatic run_frame(input string name, input logic [27:0] exp_seg,
                            input logic [3:0] lit, input int b_lo, input int b_hi,
                            input int chg_at, input logic [15:0] chg_val);
      int         k;
      logic       shown;
      logic [3:0] e_an;
      logic       e_dp;
      blank = (1 >= b_lo) && (1 <= b_hi);
      for (int i = 1; i <= 4 * P; i++) begin
         @(negedge clk);
         k     = (i - 1) / P;
         shown = lit[k] && !((i >= b_lo) && (i <= b_hi));
         e_an  = shown ? ~(4'b0001 << k) : 4'b1111;
         e_dp  = shown ? ~dp_mask[k] : 1'b1;
         check($sformatf("%s an c%0d", name, i),    32'(an),    32'(e_an));
         check($sformatf("%s seg c%0d", name, i),   32'(seg),   32'(exp_seg[7*k +: 7]));
         check($sformatf("%s dp c%0d", name, i),    32'(dp),    32'(e_dp));
         check($sformatf("%s frame c%0d", name, i), 32'(frame), 32'(i == 4 * P));
         blank = ((i + 1) >= b_lo) && ((i + 1) <= b_hi);
         if (i == chg_at) value = chg_val;
      end
      blank = 1'b0;
   endtask

   initial begin
      // Reset held with random inputs.
      rst     = 1'b0;
      value   = 16'($urandom);
      dp_mask = 4'($urandom);
      blank   = 1'($urandom);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset hold a");
      value   = 16'($urandom);
      dp_mask = 4'($urandom);
      blank   = 1'($urandom);
      @(negedge clk);
      check_reset_outputs("reset hold b");

      // Release and check first-tick timing.
      value   = 16'h1234;
      dp_mask = 4'b0000;
      blank   = 1'b0;
      rst     = 1'b1;
      startup("start");

      // Basic scan of 1234. value switches to ABCD while digit 2 shows, and
      // the rest of the frame must still show 2 and 1.
      run_frame("f1_1234", SEG_1234, 4'b1111, 0, -1, 2 * P + 1, 16'hABCD);

      // New snapshot. dp on digit 2 and blank for 6 edges (3..8), starting
      // in slot 0 and released just before slot 2.
      dp_mask = 4'b0100;
      run_frame("f2_abcd_blank", SEG_ABCD, 4'b1111, 3, 8, 0, 16'h0000);

      // Clean frame of ABCD. Load 0070 for the next frame.
      dp_mask = 4'b0000;
      run_frame("f3_abcd", SEG_ABCD, 4'b1111, 0, -1, 1, 16'h0070);

      // Leading zeros: 0070, then 0000.
      run_frame("f4_0070", SEG_0070, LIT_0070, 0, -1, 1, 16'h0000);
      run_frame("f5_0000", SEG_0000, LIT_0000, 0, -1, 1, 16'h1234);

      // Asynchronous reset during slot 1 of the following frame.
      repeat (P + 2) @(negedge clk);
      check("pre-reset an", 32'(an), 32'h0000000D);
      #2 rst = 1'b0;
      #1 check_reset_outputs("async reset");
      @(negedge clk);
      check_reset_outputs("async reset held");
      value = 16'h1234;
      rst   = 1'b1;
      startup("restart");
      run_frame("f7_1234", SEG_1234, 4'b1111, 0, -1, 0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Four-digit multiplexed hexadecimal display driver for the 16-bit up/down counter. It sits directly downstream of the counter, consuming its `cnt` bus and driving the board's common-anode 7-segment module. A prescaler times each digit slot, and a 2-bit scan index rotates the anodes. The input value is snapshotted once per scan frame, so all four digits of a frame always show one coherent count.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: reset; asynchronous, active-low.
- `value`  in  16: value to display; digit *k* shows `value[4k+3:4k]`.
- `dp_mask`  in  4: decimal point request per digit; bit *k* = 1 lights the dp of digit *k*.
- `blank`  in  1: synchronous; 1 turns all anodes off.
- `an`  out  4: anode enables, active-low, one-hot-low while scanning.
- `seg`  out  7: segments, active-low, bit order `{g,f,e,d,c,b,a}`.
- `dp`  out  1: decimal point, active-low.
- `frame`  out  1: one-cycle pulse on each snapshot load, i.e. frame start.

## Operation
- **Prescaler.** `pc` counts 0..PRESCALE−1 and wraps to 0. `tick` = (`pc` == PRESCALE−1). The counter width is `$clog2(PRESCALE)`.
- **Scan state.** Registers are digit index `d[1:0]`, flag `run`, and snapshot `shadow[15:0]`.
- **Transition on `tick`:**
  - If `!run` or `d` == 3: `d` ← 0, `shadow` ← `value`, `run` ← 1, `frame` ← 1.
  - Otherwise: `d` ← `d`+1, `frame` ← 0.
  - `frame` is 0 on every non-tick cycle.
- **Output register.** This register is loaded every cycle from the state registers, not from next-state.
  - `an` ← ~(1 << `d`) when `run` && !`blank`; otherwise 4'b1111.
  - `seg` ← decode(`shadow` nibble `d`) when `run`; otherwise 7'b1111111.
  - `dp` ← ~`dp_mask[d]` when `run` && !`blank`; otherwise 1.
- **Decode** (hex, `{g..a}`): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- **`blank`:**
  - Affects `an` and `dp` only.
  - Prescaler, scan and snapshot keep running, so releasing `blank` resumes on the current digit.
- **`value` and `dp_mask`:**
  - `value` is sampled only at frame start; changes mid-frame are invisible until the next frame.
  - `dp_mask` is sampled live every cycle.

## Timing
- **Reset values:** `pc`=0, `d`=0, `run`=0, `shadow`=0, `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame`=0.
- **First tick after reset release** is at cycle PRESCALE−1 (`pc` reaching PRESCALE−1). `frame` is high during the following cycle. `an`=4'b1110 from the cycle after that.
- **Latency:**
  - State update to pin change is 1 cycle.
  - `value` change to display is ≤ 4·PRESCALE+1 cycles.
  - `blank` to `an` is 1 cycle.
- **Slots and frames:** each digit slot lasts exactly PRESCALE cycles. A frame is 4·PRESCALE cycles. Anodes never overlap; exactly one `an` bit is low while scanning and not blanked.
- **Reset mid-frame** forces all reset values immediately, asynchronously. After release, the block restarts from the first-tick behaviour above.

## Configuration
- **`SEG7_LZB_EN` defined:** leading-zero blanking. Digit *k* (k = 1..3) is suppressed when `shadow[15:4k]` == 0.
  - "Suppressed" means `an` stays 4'b1111 and `dp` stays 1 for that slot.
  - Slot timing is unchanged.
  - Digit 0 is always shown.
- **`SEG7_LZB_EN` undefined:** all four digits are always shown, including leading zeros.

## Test plan
- **Reset:** hold `rst`=0 with random inputs → `an`=F, `seg`=7F, `dp`=1, `frame`=0. Assert `rst` asynchronously mid-scan → these values appear without waiting for a clock edge.
- **Basic scan:** PRESCALE=4, `value`=16'h1234, `dp_mask`=0 → `frame` pulses every 16 cycles. `an` cycles E, D, B, 7, each held for 4 cycles. `seg` is 19, 30, 24, 79 respectively.
- **Snapshot:** change `value` 16'h1234→16'hABCD while digit 2 is showing → the rest of the frame still shows 2 and 1. The next frame shows D, C, b, A (seg 21, 46, 03, 08).
- **Blank and dp:** `dp_mask`=4'b0100 → `dp`=0 only during the digit-2 slot. `blank`=1 for 6 cycles → `an`=F one cycle after assertion. After release, scan resumes on the same slot position with no phase shift of `frame`.
- **LZB on** (`SEG7_LZB_EN` defined): `value`=16'h0070 → only digits 0 and 1 light (`an` E, D; digits 2 and 3 stay F). `value`=0 → only digit 0 lights, showing seg 40.
- **LZB off** (`SEG7_LZB_EN` undefined): same stimulus → all four anodes light, with digits 2 and 3 showing seg 40.
